// File: rtl/lsu_axil_master.sv
// Load/store unit bus master. Accepts one load or store at a time from the
// execute stage and turns it into an AXI-lite style AR/R or AW/W/B exchange.
// Store data is replicated across byte lanes with matching strobes. Load data
// is shifted down to bit 0 and sign- or zero-extended. Exactly one response is
// returned per accepted request. Every output comes straight from a register.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_*             request from execute (valid/ready, wen, addr, wdata, size, unsigned)
//   resp_*            response to writeback (valid/ready, rdata, err)
//   araddr/arvalid/arready, rdata/rresp/rvalid/rready     read channels
//   awaddr/awvalid/awready, wdata/wstrb/wvalid/wready     write request channels
//   bresp/bvalid/bready                                   write response channel
module lsu_axil_master #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32  // only 32 is supported
) (
   input  logic              clk,
   input  logic              rst,
   // request
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wen,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   // response
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   // read address / data
   output logic [ADDR_W-1:0] araddr,
   output logic              arvalid,
   input  logic              arready,
   input  logic [DATA_W-1:0] rdata,
   input  logic              rresp,
   input  logic              rvalid,
   output logic              rready,
   // write address / data / response
   output logic [ADDR_W-1:0] awaddr,
   output logic              awvalid,
   input  logic              awready,
   output logic [DATA_W-1:0] wdata,
   output logic [31:0]       wstrb,
   output logic              wvalid,
   input  logic              wready,
   output logic              bready,
   input  logic              bresp,
   input  logic              bvalid
);

   typedef enum logic [2:0] {
      StIdle,
      StRdAddr,
      StRdData,
      StWrReq,
      StWrResp,
      StResp
   } state_e;

   state_e state_q, state_d;

   logic              req_ready_q, req_ready_d;
   logic              resp_valid_q, resp_valid_d;
   logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
   logic              resp_err_q, resp_err_d;
   logic [ADDR_W-1:0] araddr_q, araddr_d;
   logic              arvalid_q, arvalid_d;
   logic              rready_q, rready_d;
   logic [ADDR_W-1:0] awaddr_q, awaddr_d;
   logic              awvalid_q, awvalid_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [31:0]       wstrb_q, wstrb_d;
   logic              wvalid_q, wvalid_d;
   logic              bready_q, bready_d;
   logic              aw_done_q, aw_done_d;
   logic              w_done_q, w_done_d;
   // Request attributes kept for the load extension step.
   logic [1:0]        off_q, off_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;

   // Request decode: alignment/size legality and store lane placement.
   logic              req_bad;
   logic [DATA_W-1:0] lane_wdata;
   logic [3:0]        lane_strb;

   always_comb begin
      req_bad = (req_size == 2'd3)
             || ((req_size == 2'd1) && req_addr[0])
             || ((req_size == 2'd2) && (req_addr[1:0] != 2'd0));
   end

   always_comb begin
      lane_wdata = req_wdata;
      lane_strb  = 4'hF;
      case (req_size)
         2'd0: begin
            lane_wdata = {4{req_wdata[7:0]}};
            lane_strb  = 4'b0001 << req_addr[1:0];
         end
         2'd1: begin
            lane_wdata = {2{req_wdata[15:0]}};
            lane_strb  = 4'b0011 << req_addr[1:0];
         end
         default: ;
      endcase
   end

   // Load data: bring the addressed bytes down to bit 0, then extend.
   logic [DATA_W-1:0] rd_shift;
   logic [DATA_W-1:0] rd_ext;

   always_comb begin
      rd_shift = rdata >> {off_q, 3'b000};
      rd_ext   = rd_shift;
      case (size_q)
         2'd0: rd_ext = uns_q ? {24'd0, rd_shift[7:0]}
                              : {{24{rd_shift[7]}}, rd_shift[7:0]};
         2'd1: rd_ext = uns_q ? {16'd0, rd_shift[15:0]}
                              : {{16{rd_shift[15]}}, rd_shift[15:0]};
         default: ;
      endcase
   end

   // Next-state and next-output logic.
   logic aw_now, w_now;

   always_comb begin
      state_d      = state_q;
      req_ready_d  = req_ready_q;
      resp_valid_d = resp_valid_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      araddr_d     = araddr_q;
      arvalid_d    = arvalid_q;
      rready_d     = rready_q;
      awaddr_d     = awaddr_q;
      awvalid_d    = awvalid_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      wvalid_d     = wvalid_q;
      bready_d     = bready_q;
      aw_done_d    = aw_done_q;
      w_done_d     = w_done_q;
      off_d        = off_q;
      size_d       = size_q;
      uns_d        = uns_q;
      aw_now       = aw_done_q | (awvalid_q & awready);
      w_now        = w_done_q | (wvalid_q & wready);

      unique case (state_q)
         StIdle: begin
            if (req_valid && req_ready_q) begin
               req_ready_d = 1'b0;
               off_d       = req_addr[1:0];
               size_d      = req_size;
               uns_d       = req_unsigned;
               if (req_bad) begin
                  // Rejected without touching the bus.
                  resp_err_d   = 1'b1;
                  resp_rdata_d = '0;
                  state_d      = StResp;
               end else if (req_wen) begin
                  awaddr_d  = req_addr;
                  awvalid_d = 1'b1;
                  wdata_d   = lane_wdata;
                  wstrb_d   = {28'd0, lane_strb};
                  wvalid_d  = 1'b1;
                  aw_done_d = 1'b0;
                  w_done_d  = 1'b0;
                  state_d   = StWrReq;
               end else begin
                  araddr_d  = req_addr;
                  arvalid_d = 1'b1;
                  state_d   = StRdAddr;
               end
            end
         end

         StRdAddr: begin
            if (arvalid_q && arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = StRdData;
            end
         end

         StRdData: begin
            if (rvalid && rready_q) begin
               rready_d     = 1'b0;
               resp_rdata_d = rd_ext;
               resp_err_d   = rresp;
               state_d      = StResp;
            end
         end

         StWrReq: begin
            // AW and W complete independently, in either order.
            if (awvalid_q && awready) awvalid_d = 1'b0;
            if (wvalid_q && wready)   wvalid_d  = 1'b0;
            aw_done_d = aw_now;
            w_done_d  = w_now;
            if (aw_now && w_now) begin
               bready_d = 1'b1;
               state_d  = StWrResp;
            end
         end

         StWrResp: begin
            if (bvalid && bready_q) begin
               bready_d     = 1'b0;
               resp_err_d   = bresp;
               resp_rdata_d = '0;
               state_d      = StResp;
            end
         end

         StResp: begin
            // resp_valid rises one cycle after entry and holds until taken.
            if (resp_valid_q && resp_ready) begin
               resp_valid_d = 1'b0;
               req_ready_d  = 1'b1;
               state_d      = StIdle;
            end else begin
               resp_valid_d = 1'b1;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
         araddr_q     <= '0;
         arvalid_q    <= 1'b0;
         rready_q     <= 1'b0;
         awaddr_q     <= '0;
         awvalid_q    <= 1'b0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         wvalid_q     <= 1'b0;
         bready_q     <= 1'b0;
         aw_done_q    <= 1'b0;
         w_done_q     <= 1'b0;
         off_q        <= '0;
         size_q       <= '0;
         uns_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
         araddr_q     <= araddr_d;
         arvalid_q    <= arvalid_d;
         rready_q     <= rready_d;
         awaddr_q     <= awaddr_d;
         awvalid_q    <= awvalid_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         wvalid_q     <= wvalid_d;
         bready_q     <= bready_d;
         aw_done_q    <= aw_done_d;
         w_done_q     <= w_done_d;
         off_q        <= off_d;
         size_q       <= size_d;
         uns_q        <= uns_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;
   assign araddr     = araddr_q;
   assign arvalid    = arvalid_q;
   assign rready     = rready_q;
   assign awaddr     = awaddr_q;
   assign awvalid    = awvalid_q;
   assign wdata      = wdata_q;
   assign wstrb      = wstrb_q;
   assign wvalid     = wvalid_q;
   assign bready     = bready_q;

endmodule

// File: tb/tb_lsu_axil_master.sv
module tb_lsu_axil_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_wen = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [1:0]  req_size = '0;
   logic        req_unsigned = 1'b0;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready = 1'b1;
   logic [31:0] rdata = '0;
   logic        rresp = 1'b0;
   logic        rvalid = 1'b0;
   logic        rready;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready = 1'b1;
   logic [31:0] wdata;
   logic [31:0] wstrb;
   logic        wvalid;
   logic        wready = 1'b1;
   logic        bready;
   logic        bresp = 1'b0;
   logic        bvalid = 1'b0;

   always #5 clk = ~clk;

   lsu_axil_master #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
      .req_unsigned(req_unsigned),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
      .resp_err(resp_err),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bready(bready), .bresp(bresp), .bvalid(bvalid)
   );

   // Slave knobs.
   logic [31:0] slv_rdata = '0;
   logic        slv_rresp = 1'b0;
   logic        slv_bresp = 1'b0;
   logic        slv_r_hold = 1'b0;

   // Handshake counters and captured channel contents.
   int          ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
   int          resp_cnt = 0, arv_cnt = 0;
   logic [31:0] cap_araddr = '0, cap_awaddr = '0, cap_wdata = '0, cap_wstrb = '0;
   logic        aw_seen = 1'b0, w_seen = 1'b0;

   logic aw_hs, w_hs;
   assign aw_hs = awvalid && awready;
   assign w_hs  = wvalid && wready;

   // Slave: read data one cycle after AR; B one cycle after both AW and W.
   always @(posedge clk) begin
      if (rst) begin
         rvalid  <= 1'b0;
         bvalid  <= 1'b0;
         aw_seen <= 1'b0;
         w_seen  <= 1'b0;
      end else begin
         if (arvalid && arready && !slv_r_hold) begin
            rvalid <= 1'b1;
            rdata  <= slv_rdata;
            rresp  <= slv_rresp;
         end else if (rvalid && rready) begin
            rvalid <= 1'b0;
         end
         if (bvalid && bready) begin
            bvalid <= 1'b0;
         end else if (!bvalid && (aw_seen || aw_hs) && (w_seen || w_hs)) begin
            bvalid  <= 1'b1;
            bresp   <= slv_bresp;
            aw_seen <= 1'b0;
            w_seen  <= 1'b0;
         end else begin
            if (aw_hs) aw_seen <= 1'b1;
            if (w_hs)  w_seen  <= 1'b1;
         end
      end
   end

   always @(posedge clk) begin
      if (!rst) begin
         if (arvalid) arv_cnt <= arv_cnt + 1;
         if (arvalid && arready) begin ar_cnt <= ar_cnt + 1; cap_araddr <= araddr; end
         if (rvalid && rready) r_cnt <= r_cnt + 1;
         if (aw_hs) begin aw_cnt <= aw_cnt + 1; cap_awaddr <= awaddr; end
         if (w_hs) begin w_cnt <= w_cnt + 1; cap_wdata <= wdata; cap_wstrb <= wstrb; end
         if (bvalid && bready) b_cnt <= b_cnt + 1;
         if (resp_valid && resp_ready) resp_cnt <= resp_cnt + 1;
      end
   end

   int          checks = 0;
   int          errors = 0;
   bit          got;
   int          lat;
   logic [31:0] rd;
   logic        re;

   task automatic send_req(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [1:0] sz, input logic uns);
      @(negedge clk);
      req_valid    = 1'b1;
      req_wen      = wen;
      req_addr     = addr;
      req_wdata    = wd;
      req_size     = sz;
      req_unsigned = uns;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   // Waits (bounded) for resp_valid; lat counts negedges since the accepting edge.
   task automatic wait_resp();
      got = 1'b0;
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (resp_valid) begin
            got = 1'b1;
            lat = i;
            break;
         end
      end
      rd = resp_rdata;
      re = resp_err;
      if (got && resp_ready) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
      checks++; if ({arvalid, rready, awvalid, wvalid, bready} !== 5'b0) begin
         errors++; $display("FAIL reset_bus_valids got %b exp 00000", {arvalid, rready, awvalid, wvalid, bready});
      end
      checks++; if ({resp_valid, resp_err, resp_rdata} !== 34'd0) begin
         errors++; $display("FAIL reset_resp got %b/%b/%h exp 0/0/0", resp_valid, resp_err, resp_rdata);
      end
      checks++; if ({araddr, awaddr, wdata, wstrb} !== 128'd0) begin
         errors++; $display("FAIL reset_bus_data got %h %h %h %h exp 0", araddr, awaddr, wdata, wstrb);
      end
      rst = 1'b0;
   endtask

   task automatic test_word_load();
      int a0, r0;
      a0 = ar_cnt; r0 = r_cnt;
      slv_rdata = 32'hDEADBEEF; slv_rresp = 1'b0; resp_ready = 1'b1;
      send_req(1'b0, 32'h80000004, 32'h0, 2'd2, 1'b0);
      wait_resp();
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL word_load_timeout got %b exp 1", got); end
      checks++; if (lat !== 4) begin errors++; $display("FAIL word_load_latency got %0d exp 4", lat); end
      checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL word_load_rdata got %h exp deadbeef", rd); end
      checks++; if (re !== 1'b0) begin errors++; $display("FAIL word_load_err got %b exp 0", re); end
      checks++; if (cap_araddr !== 32'h80000004) begin errors++; $display("FAIL word_load_araddr got %h exp 80000004", cap_araddr); end
      checks++; if ((ar_cnt - a0) !== 1 || (r_cnt - r0) !== 1) begin
         errors++; $display("FAIL word_load_handshakes got ar=%0d r=%0d exp 1 1", ar_cnt - a0, r_cnt - r0);
      end
      @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL word_load_ready_after got %b exp 1", req_ready); end
   endtask

   task automatic test_byte_load();
      slv_rdata = 32'h80FFFFFF; slv_rresp = 1'b0;
      send_req(1'b0, 32'h80000003, 32'h0, 2'd0, 1'b0);
      wait_resp();
      checks++; if (!got || rd !== 32'hFFFFFF80) begin errors++; $display("FAIL byte_load_signed got %h exp ffffff80", rd); end
      send_req(1'b0, 32'h80000003, 32'h0, 2'd0, 1'b1);
      wait_resp();
      checks++; if (!got || rd !== 32'h00000080) begin errors++; $display("FAIL byte_load_unsigned got %h exp 00000080", rd); end
      slv_rdata = 32'h1234F00D;
      send_req(1'b0, 32'h80000000, 32'h0, 2'd1, 1'b1);
      wait_resp();
      checks++; if (!got || rd !== 32'h0000F00D) begin errors++; $display("FAIL half_load_unsigned got %h exp 0000f00d", rd); end
   endtask

   task automatic test_half_store();
      slv_bresp = 1'b0;
      send_req(1'b1, 32'h80000002, 32'h1234ABCD, 2'd1, 1'b0);
      wait_resp();
      checks++; if (cap_wdata !== 32'hABCDABCD) begin errors++; $display("FAIL half_store_wdata got %h exp abcdabcd", cap_wdata); end
      checks++; if (cap_wstrb !== 32'h0000000C) begin errors++; $display("FAIL half_store_wstrb got %h exp 0000000c", cap_wstrb); end
      checks++; if (cap_awaddr !== 32'h80000002) begin errors++; $display("FAIL half_store_awaddr got %h exp 80000002", cap_awaddr); end
      checks++; if (!got || re !== 1'b0 || rd !== 32'h0) begin
         errors++; $display("FAIL half_store_resp got valid=%b err=%b rdata=%h exp 1 0 0", got, re, rd);
      end
      checks++; if (lat !== 4) begin errors++; $display("FAIL half_store_latency got %0d exp 4", lat); end
   endtask

   task automatic test_w_first();
      int aw0, w0, b0, p0;
      aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; p0 = resp_cnt;
      awready = 1'b0; wready = 1'b1;
      send_req(1'b1, 32'h80000010, 32'h000000AB, 2'd0, 1'b0);
      @(negedge clk);
      checks++; if ({awvalid, wvalid, bready} !== 3'b110) begin
         errors++; $display("FAIL wfirst_start got aw/w/b=%b exp 110", {awvalid, wvalid, bready});
      end
      @(negedge clk);
      checks++; if ({awvalid, wvalid, bready} !== 3'b100) begin
         errors++; $display("FAIL wfirst_w_done got aw/w/b=%b exp 100", {awvalid, wvalid, bready});
      end
      @(negedge clk);
      checks++; if (bready !== 1'b0) begin errors++; $display("FAIL wfirst_bready_early got %b exp 0", bready); end
      awready = 1'b1;
      @(negedge clk);
      checks++; if ({awvalid, bready} !== 2'b01) begin
         errors++; $display("FAIL wfirst_both_done got aw/b=%b exp 01", {awvalid, bready});
      end
      wait_resp();
      repeat (3) @(negedge clk);
      checks++; if ((aw_cnt - aw0) !== 1 || (w_cnt - w0) !== 1 || (b_cnt - b0) !== 1 || (resp_cnt - p0) !== 1) begin
         errors++; $display("FAIL wfirst_counts got aw=%0d w=%0d b=%0d resp=%0d exp 1 1 1 1",
                            aw_cnt - aw0, w_cnt - w0, b_cnt - b0, resp_cnt - p0);
      end
      checks++; if (cap_wdata !== 32'hABABABAB || cap_wstrb !== 32'h1) begin
         errors++; $display("FAIL wfirst_lanes got %h/%h exp abababab/00000001", cap_wdata, cap_wstrb);
      end
   endtask

   task automatic test_misaligned();
      int v0, aw0;
      v0 = arv_cnt; aw0 = aw_cnt;
      send_req(1'b0, 32'h80000002, 32'h0, 2'd2, 1'b0);
      wait_resp();
      checks++; if (!got || lat !== 2) begin errors++; $display("FAIL misaligned_latency got %0d exp 2", lat); end
      checks++; if (re !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL misaligned_err got %b/%h exp 1/0", re, rd); end
      checks++; if ((arv_cnt - v0) !== 0) begin errors++; $display("FAIL misaligned_no_ar got %0d exp 0", arv_cnt - v0); end
      send_req(1'b1, 32'h80000001, 32'h5555, 2'd1, 1'b0);
      wait_resp();
      checks++; if (!got || re !== 1'b1) begin errors++; $display("FAIL misaligned_half_store got %b exp 1", re); end
      send_req(1'b1, 32'h80000000, 32'h5555, 2'd3, 1'b0);
      wait_resp();
      checks++; if (!got || re !== 1'b1 || lat !== 2) begin
         errors++; $display("FAIL illegal_size got err=%b lat=%0d exp 1 2", re, lat);
      end
      checks++; if ((aw_cnt - aw0) !== 0) begin errors++; $display("FAIL illegal_no_aw got %0d exp 0", aw_cnt - aw0); end
   endtask

   task automatic test_errors();
      slv_rdata = 32'h80015555; slv_rresp = 1'b1;
      send_req(1'b0, 32'h80000002, 32'h0, 2'd1, 1'b0);
      wait_resp();
      checks++; if (!got || rd !== 32'hFFFF8001 || re !== 1'b1) begin
         errors++; $display("FAIL read_error got %h/%b exp ffff8001/1", rd, re);
      end
      slv_rresp = 1'b0; slv_bresp = 1'b1;
      send_req(1'b1, 32'h80000020, 32'h11223344, 2'd2, 1'b0);
      wait_resp();
      checks++; if (!got || rd !== 32'h0 || re !== 1'b1) begin
         errors++; $display("FAIL write_error got %h/%b exp 0/1", rd, re);
      end
      checks++; if (cap_wdata !== 32'h11223344 || cap_wstrb !== 32'hF) begin
         errors++; $display("FAIL word_store_lanes got %h/%h exp 11223344/0000000f", cap_wdata, cap_wstrb);
      end
      slv_bresp = 1'b0;
   endtask

   task automatic test_back_to_back();
      int p0;
      p0 = resp_cnt;
      slv_rdata = 32'hCAFEF00D; resp_ready = 1'b0;
      send_req(1'b0, 32'h80000008, 32'h0, 2'd2, 1'b0);
      wait_resp();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if ({resp_valid, req_ready} !== 2'b10 || resp_rdata !== 32'hCAFEF00D) begin
            errors++; $display("FAIL resp_hold got v=%b rr=%b d=%h exp 1 0 cafef00d", resp_valid, req_ready, resp_rdata);
         end
      end
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++; if ({resp_valid, req_ready} !== 2'b01) begin
         errors++; $display("FAIL resp_release got v=%b rr=%b exp 0 1", resp_valid, req_ready);
      end
      slv_rdata = 32'h0000A5A5;
      send_req(1'b0, 32'h80000004, 32'h0, 2'd1, 1'b0);
      wait_resp();
      checks++; if (!got || rd !== 32'hFFFFA5A5 || (resp_cnt - p0) !== 2) begin
         errors++; $display("FAIL back_to_back got %h cnt=%0d exp ffffa5a5 2", rd, resp_cnt - p0);
      end
   endtask

   task automatic test_reset_mid();
      int p0;
      slv_r_hold = 1'b1; resp_ready = 1'b0;
      send_req(1'b0, 32'h80000000, 32'h0, 2'd2, 1'b0);
      @(negedge clk);
      @(negedge clk);
      checks++; if (rready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_rdata got %b exp 1", rready); end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         errors++; $display("FAIL rst_mid_ctrl got rr=%b v=%b exp 1 0", req_ready, resp_valid);
      end
      checks++; if ({arvalid, rready, awvalid, wvalid, bready} !== 5'b0) begin
         errors++; $display("FAIL rst_mid_bus got %b exp 00000", {arvalid, rready, awvalid, wvalid, bready});
      end
      rst = 1'b0; slv_r_hold = 1'b0; resp_ready = 1'b1;
      p0 = resp_cnt;
      repeat (4) @(negedge clk);
      checks++; if (resp_valid !== 1'b0 || (resp_cnt - p0) !== 0) begin
         errors++; $display("FAIL rst_mid_no_resp got v=%b cnt=%0d exp 0 0", resp_valid, resp_cnt - p0);
      end
      slv_rdata = 32'h11223344;
      send_req(1'b0, 32'h80000001, 32'h0, 2'd0, 1'b1);
      wait_resp();
      checks++; if (!got || lat !== 4 || rd !== 32'h00000033 || re !== 1'b0) begin
         errors++; $display("FAIL rst_mid_recover got %h/%b lat=%0d exp 00000033/0 4", rd, re, lat);
      end
   endtask

   initial begin
      test_reset();
      test_word_load();
      test_byte_load();
      test_half_store();
      test_w_first();
      test_misaligned();
      test_errors();
      test_back_to_back();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
